// File: rtl/nes_poll_ctrl_if.sv
// CPU-side register bus for nes_poll_ctrl: one-cycle access strobe,
// registered read data with a one-cycle valid pulse.
interface nes_poll_ctrl_if;
    logic        bus_sel;
    logic        bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_sel, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_sel, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/nes_poll_ctrl.sv
// nes_poll_ctrl: periodically triggers nes_bridge, waits for it to settle,
// reads its four result bytes into a snapshot and exposes snapshot, sticky
// newly-pressed bits, a commit counter and an interrupt on a 32-bit bus.
module nes_poll_ctrl #(
    parameter int unsigned POLL_PERIOD   = 833_333,
    parameter int unsigned SETTLE_CYCLES = 50_000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    nes_poll_ctrl_if.slave        bus,
    output logic                  br_start,
    output logic [1:0]            br_addr,
    input  logic [7:0]            br_rdata,
    output logic                  irq
);

    localparam int unsigned TW = (POLL_PERIOD > 1)   ? $clog2(POLL_PERIOD)   : 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST  = TW'(POLL_PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SETTLE,
        ST_READ,
        ST_COMMIT
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   wait_q, wait_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     pressed_q, pressed_d;
    logic [15:0]     seq_q, seq_d;
    logic            enable_q, enable_d;
    logic            irq_en_q, irq_en_d;
    logic            valid_q, valid_d;
    logic            pend_q, pend_d;
    logic            ovr_q, ovr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;

    logic            tick;
    logic            capture;
    logic            commit;
    logic [7:0]      byte_in;
    logic [31:0]     edges;
    logic            wr, rd, wr_ctrl, wr_pressed;
    logic [31:0]     rd_mux;
    logic            unused_addr;

    assign unused_addr = ^bus.bus_addr[1:0];

    assign tick    = enable_q && (timer_q == TIMER_LAST);
    assign byte_in = ACTIVE_LOW ? ~br_rdata : br_rdata;
    assign edges   = shadow_q & ~data_q;

    assign wr         = bus.bus_sel &  bus.bus_we;
    assign rd         = bus.bus_sel & ~bus.bus_we;
    assign wr_ctrl    = wr && (bus.bus_addr[3:2] == 2'd0);
    assign wr_pressed = wr && (bus.bus_addr[3:2] == 2'd2);

    assign irq            = irq_en_q & pend_q;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;

    // Poll sequencer: next state, bridge strobes and capture/commit controls.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        br_start = 1'b0;
        br_addr  = '0;
        capture  = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_START;
            end
            ST_START: begin
                br_start = 1'b1;
                wait_d   = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_READ: begin
                br_addr = idx_q;
                capture = 1'b1;
                if (idx_q == 2'd3) begin
                    idx_d   = '0;
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file, poll timer, shadow capture and read path next-state.
    // W1C clears act on the old value so bits set by a concurrent commit survive.
    always_comb begin
        timer_d = enable_q ? (tick ? '0 : timer_q + 1'b1) : '0;

        shadow_d = shadow_q;
        if (capture) shadow_d[idx_q] = byte_in;

        enable_d  = wr_ctrl ? bus.bus_wdata[0] : enable_q;
        irq_en_d  = wr_ctrl ? bus.bus_wdata[1] : irq_en_q;
        valid_d   = valid_q | commit;
        pend_d    = (pend_q & ~(wr_ctrl & bus.bus_wdata[3])) | (commit & (|edges));
        ovr_d     = (ovr_q  & ~(wr_ctrl & bus.bus_wdata[4])) | (tick & (state_q != ST_IDLE));
        pressed_d = (pressed_q & ~(wr_pressed ? bus.bus_wdata : '0)) | (commit ? edges : '0);
        data_d    = commit ? shadow_q : data_q;
        seq_d     = commit ? seq_q + 1'b1 : seq_q;

        case (bus.bus_addr[3:2])
            2'd0:    rd_mux = {27'd0, ovr_q, pend_q, valid_q, irq_en_q, enable_q};
            2'd1:    rd_mux = data_q;
            2'd2:    rd_mux = pressed_q;
            default: rd_mux = {16'd0, seq_q};
        endcase
        rdata_d  = rd ? rd_mux : rdata_q;
        rvalid_d = rd;
    end

    // State and register update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            wait_q    <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            pressed_q <= '0;
            seq_q     <= '0;
            enable_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            pressed_q <= pressed_d;
            seq_q     <= seq_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            valid_q   <= valid_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_nes_poll_ctrl.sv
// Bench for nes_poll_ctrl: instance A (period 100, settle 20) and a stalling
// instance B (period 100, settle 120). Reads push expected words into a
// per-bus queue; a monitor pops and compares on every rvalid.
module tb_nes_poll_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    nes_poll_ctrl_if ifa ();
    nes_poll_ctrl_if ifb ();

    logic       br_start_a, br_start_b;
    logic [1:0] br_addr_a, br_addr_b;
    logic [7:0] br_rdata_a, br_rdata_b;
    logic       irq_a, irq_b;
    logic [7:0] bytes_a [4];
    logic [7:0] bytes_b [4];

    assign br_rdata_a = bytes_a[br_addr_a];
    assign br_rdata_b = bytes_b[br_addr_b];

    nes_poll_ctrl #(.POLL_PERIOD(100), .SETTLE_CYCLES(20), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa),
        .br_start(br_start_a), .br_addr(br_addr_a), .br_rdata(br_rdata_a), .irq(irq_a)
    );

    nes_poll_ctrl #(.POLL_PERIOD(100), .SETTLE_CYCLES(120), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb),
        .br_start(br_start_b), .br_addr(br_addr_b), .br_rdata(br_rdata_b), .irq(irq_b)
    );

    logic [31:0] exp_qa [$];
    string       name_qa [$];
    logic [31:0] exp_qb [$];
    string       name_qb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every read response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (ifa.bus_rvalid === 1'b1) begin
            if (exp_qa.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL A unexpected rvalid: got %08h expected none", ifa.bus_rdata);
            end else begin
                chk(name_qa.pop_front(), ifa.bus_rdata, exp_qa.pop_front());
            end
        end
        if (ifb.bus_rvalid === 1'b1) begin
            if (exp_qb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL B unexpected rvalid: got %08h expected none", ifb.bus_rdata);
            end else begin
                chk(name_qb.pop_front(), ifb.bus_rdata, exp_qb.pop_front());
            end
        end
    end

    // All bus tasks are entered 1 ns after a rising edge and return 1 ns after the next.
    task automatic bus_write(input bit b, input logic [3:0] a, input logic [31:0] d);
        if (b) begin
            ifb.bus_sel = 1'b1; ifb.bus_we = 1'b1; ifb.bus_addr = a; ifb.bus_wdata = d;
        end else begin
            ifa.bus_sel = 1'b1; ifa.bus_we = 1'b1; ifa.bus_addr = a; ifa.bus_wdata = d;
        end
        @(posedge clk); #1;
        ifa.bus_sel = 1'b0; ifb.bus_sel = 1'b0;
        ifa.bus_we  = 1'b0; ifb.bus_we  = 1'b0;
    endtask

    task automatic bus_read(input bit b, input logic [3:0] a, input logic [31:0] exp, input string name);
        if (b) begin
            exp_qb.push_back(exp); name_qb.push_back(name);
            ifb.bus_sel = 1'b1; ifb.bus_we = 1'b0; ifb.bus_addr = a;
        end else begin
            exp_qa.push_back(exp); name_qa.push_back(name);
            ifa.bus_sel = 1'b1; ifa.bus_we = 1'b0; ifa.bus_addr = a;
        end
        @(posedge clk); #1;
        ifa.bus_sel = 1'b0; ifb.bus_sel = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_start(input bit b, input string name, output int c);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if ((b ? br_start_b : br_start_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, " start timeout"}, 32'd0, 32'd1);
        c = cyc;
    endtask

    task automatic read_all_zero_a(input string tag);
        bus_read(0, 4'h0, 32'h0, {tag, " CTRL"});
        bus_read(0, 4'h4, 32'h0, {tag, " DATA"});
        bus_read(0, 4'h8, 32'h0, {tag, " PRESSED"});
        bus_read(0, 4'hC, 32'h0, {tag, " SEQ"});
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_w, c_s, c_s2, starts;
        ifa.bus_sel = 1'b0; ifa.bus_we = 1'b0; ifa.bus_addr = '0; ifa.bus_wdata = '0;
        ifb.bus_sel = 1'b0; ifb.bus_we = 1'b0; ifb.bus_addr = '0; ifb.bus_wdata = '0;
        bytes_a[0] = 8'hFE; bytes_a[1] = 8'hFF; bytes_a[2] = 8'hFF; bytes_a[3] = 8'hFF;
        bytes_b[0] = 8'hFE; bytes_b[1] = 8'hFF; bytes_b[2] = 8'hFF; bytes_b[3] = 8'hFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("reset br_start", 32'(br_start_a), 32'd0);
        chk("reset br_addr", 32'(br_addr_a), 32'd0);
        chk("reset irq", 32'(irq_a), 32'd0);
        read_all_zero_a("reset");

        // 1: first poll, byte0 bit0 pressed
        bus_write(0, 4'h0, 32'h3);
        c_w = cyc;
        wait_start(0, "t1", c_s);
        chk("t1 start latency", 32'(c_s - c_w), 32'd100);
        chk("t1 br_addr at start", 32'(br_addr_a), 32'd0);
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t1 br_addr k=%0d", k), 32'(br_addr_a),
                (k >= 21 && k <= 24) ? 32'(k - 21) : 32'd0);
            chk($sformatf("t1 br_start k=%0d", k), 32'(br_start_a), 32'd0);
            chk($sformatf("t1 irq k=%0d", k), 32'(irq_a), (k >= 26) ? 32'd1 : 32'd0);
        end
        bus_read(0, 4'h0, 32'h0000000F, "t1 CTRL");
        bus_read(0, 4'h4, 32'h00000001, "t1 DATA");
        bus_read(0, 4'h8, 32'h00000001, "t1 PRESSED");
        bus_read(0, 4'hE, 32'h00000001, "t1 SEQ");

        // 2: clear sticky state, unchanged bytes produce no edge
        bus_write(0, 4'h8, 32'h1);
        bus_write(0, 4'h0, 32'hB);
        chk("t2 irq after clear", 32'(irq_a), 32'd0);
        bus_read(0, 4'h0, 32'h00000007, "t2 CTRL cleared");
        bus_read(0, 4'h8, 32'h00000000, "t2 PRESSED cleared");
        wait_start(0, "t2", c_s2);
        chk("t2 poll period", 32'(c_s2 - c_s), 32'd100);
        wait_until(c_s2 + 26);
        chk("t2 irq", 32'(irq_a), 32'd0);
        bus_read(0, 4'hC, 32'h00000002, "t2 SEQ");
        bus_read(0, 4'h8, 32'h00000000, "t2 PRESSED");
        bus_read(0, 4'h0, 32'h00000007, "t2 CTRL");
        bus_read(0, 4'h4, 32'h00000001, "t2 DATA");

        // 3: new bit 1 while W1C hits PRESSED on the commit cycle
        bytes_a[0] = 8'hFC;
        wait_start(0, "t3", c_s);
        wait_until(c_s + 25);
        bus_write(0, 4'h8, 32'h3);
        bus_read(0, 4'h8, 32'h00000002, "t3 PRESSED");
        bus_read(0, 4'h4, 32'h00000003, "t3 DATA");
        bus_read(0, 4'hC, 32'h00000003, "t3 SEQ");
        bus_read(0, 4'h0, 32'h0000000F, "t3 CTRL");
        chk("t3 irq", 32'(irq_a), 32'd1);

        // 4: stalling instance, tick during poll, irq_en gating, enable cleared mid-poll
        bus_write(1, 4'h0, 32'h1);
        c_w = cyc;
        wait_start(1, "t4", c_s);
        chk("t4 start latency", 32'(c_s - c_w), 32'd100);
        wait_until(c_s + 110);
        bus_read(1, 4'h0, 32'h00000011, "t4 CTRL overrun");
        wait_until(c_s + 130);
        bus_read(1, 4'hC, 32'h00000001, "t4 SEQ first");
        bus_read(1, 4'h0, 32'h0000001D, "t4 CTRL pending");
        chk("t4 irq masked", 32'(irq_b), 32'd0);
        bus_write(1, 4'h0, 32'h13);
        chk("t4 irq on irq_en", 32'(irq_b), 32'd1);
        bus_read(1, 4'h0, 32'h0000000F, "t4 CTRL ovr cleared");
        wait_start(1, "t4b", c_s2);
        chk("t4 dropped tick", 32'(c_s2 - c_s), 32'd200);
        wait_until(c_s2 + 10);
        bus_write(1, 4'h0, 32'h2);
        wait_until(c_s2 + 130);
        bus_read(1, 4'hC, 32'h00000002, "t4 SEQ in-flight commit");
        bus_read(1, 4'h0, 32'h0000000E, "t4 CTRL disabled");
        starts = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (br_start_b === 1'b1) starts++;
        end
        chk("t4 no start when disabled", 32'(starts), 32'd0);

        // 5: async reset during START drops br_start without a clock edge
        wait_start(0, "t5", c_s);
        #2 rst = 1'b1;
        #1 chk("t5 br_start comb drop", 32'(br_start_a), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        read_all_zero_a("t5a");

        // 5b: async reset 10 cycles into SETTLE, then stay idle while disabled
        bus_write(0, 4'h0, 32'h1);
        wait_start(0, "t5b", c_s);
        wait_until(c_s + 11);
        rst = 1'b1;
        #1;
        chk("t5b br_start", 32'(br_start_a), 32'd0);
        chk("t5b br_addr", 32'(br_addr_a), 32'd0);
        chk("t5b irq", 32'(irq_a), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        read_all_zero_a("t5b");
        starts = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk); #1;
            if (br_start_a === 1'b1) starts++;
        end
        chk("t5b no poll after reset", 32'(starts), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("A reads outstanding", 32'(exp_qa.size()), 32'd0);
        chk("B reads outstanding", 32'(exp_qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
